// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line transmitter.
// The tx_state_e enum gains NCC_WAIT only when CMD_WRITE_NCC_EN is defined.
package sd_cmd_pkg;

    localparam int         CMD_TOKEN_LEN    = 48;
    localparam int         CMD_CRC_BITS_LEN = 40;
    localparam logic [6:0] CRC7_POLY        = 7'h09;
    localparam int         NCC_CYCLES       = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        CRC_OUT,
        END_BIT,
        DONE,
        LISTEN
`ifdef CMD_WRITE_NCC_EN
        ,
        NCC_WAIT
`endif
    } tx_state_e;

endpackage

// File: rtl/crc7_write.sv
// Serial CRC7 (x^7+x^3+1) generator with a shift-out mode, MSB on crc_o[6].
// Ports: sd_clk_i, rst_i, clear_i, enable_i (accumulate data_i), shift_i, crc_o.
module crc7_write
    import sd_cmd_pkg::*;
(
    input  logic       sd_clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       shift_i,
    input  logic       data_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        crc_d = crc_q;
        fb    = data_i ^ crc_q[6];
        if (clear_i) begin
            crc_d = '0;
        end else if (enable_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end else if (shift_i) begin
            // Present the next CRC bit on crc_o[6].
            crc_d = {crc_q[5:0], 1'b0};
        end
    end

    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cmd_write.sv
// SD CMD-line command transmitter: 48-bit token, MSB first, then listen pulse.
// Ports: sd_clk_i, rst_i, start_tx_i, cmd_index_i, cmd_arg_i, ready_o, cmd_o,
// cmd_en_o, done_o, start_listening_o. CMD_WRITE_NCC_EN adds an 8-cycle gap.
module cmd_write
    import sd_cmd_pkg::*;
(
    input  logic        sd_clk_i,
    input  logic        rst_i,
    input  logic        start_tx_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    output logic        ready_o,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic        done_o,
    output logic        start_listening_o
);

    localparam logic [5:0] LAST_SHIFT = 6'(CMD_CRC_BITS_LEN - 1);
    localparam logic [5:0] LAST_CRC   = 6'd6;

    tx_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] sh_q, sh_d;
    logic        crc_clr, crc_en, crc_shift;
    logic [6:0]  crc_w;
    logic        unused_crc;

    assign unused_crc = ^crc_w[5:0];

    crc7_write u_crc (
        .sd_clk_i (sd_clk_i),
        .rst_i    (rst_i),
        .clear_i  (crc_clr),
        .enable_i (crc_en),
        .shift_i  (crc_shift),
        .data_i   (sh_q[39]),
        .crc_o    (crc_w)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        sh_d              = sh_q;
        crc_clr           = 1'b0;
        crc_en            = 1'b0;
        crc_shift         = 1'b0;
        ready_o           = 1'b0;
        cmd_o             = 1'b1;
        cmd_en_o          = 1'b0;
        done_o            = 1'b0;
        start_listening_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_tx_i) begin
                    sh_d    = {2'b01, cmd_index_i, cmd_arg_i};
                    cnt_d   = '0;
                    crc_clr = 1'b1;
                    state_d = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                cmd_o    = sh_q[39];
                cmd_en_o = 1'b1;
                crc_en   = 1'b1;
                sh_d     = {sh_q[38:0], 1'b0};
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d   = '0;
                    state_d = CRC_OUT;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            CRC_OUT: begin
                cmd_o     = crc_w[6];
                cmd_en_o  = 1'b1;
                crc_shift = 1'b1;
                if (cnt_q == LAST_CRC) begin
                    cnt_d   = '0;
                    state_d = END_BIT;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            END_BIT: begin
                cmd_en_o = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = LISTEN;
            end
            LISTEN: begin
                start_listening_o = 1'b1;
`ifdef CMD_WRITE_NCC_EN
                cnt_d   = '0;
                state_d = NCC_WAIT;
`else
                state_d = IDLE;
`endif
            end
`ifdef CMD_WRITE_NCC_EN
            NCC_WAIT: begin
                if (cnt_q == 6'(NCC_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_cmd_write.sv
// Self-checking bench for cmd_write: table vectors, corner sequences and
// random commands checked against a polynomial-division token model.
module tb_cmd_write;
    import sd_cmd_pkg::*;

`ifdef CMD_WRITE_NCC_EN
    localparam int GAP = NCC_CYCLES;
`else
    localparam int GAP = 0;
`endif

    logic        sd_clk_i;
    logic        rst_i;
    logic        start_tx_i;
    logic [5:0]  cmd_index_i;
    logic [31:0] cmd_arg_i;
    logic        ready_o;
    logic        cmd_o;
    logic        cmd_en_o;
    logic        done_o;
    logic        start_listening_o;

    int total;
    int passed;
    int last_wait;

    cmd_write dut (
        .sd_clk_i          (sd_clk_i),
        .rst_i             (rst_i),
        .start_tx_i        (start_tx_i),
        .cmd_index_i       (cmd_index_i),
        .cmd_arg_i         (cmd_arg_i),
        .ready_o           (ready_o),
        .cmd_o             (cmd_o),
        .cmd_en_o          (cmd_en_o),
        .done_o            (done_o),
        .start_listening_o (start_listening_o)
    );

    initial sd_clk_i = 1'b0;
    always #5 sd_clk_i = ~sd_clk_i;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Token model: CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [47:0] mk_token(input logic [5:0] idx,
                                             input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return {m, r[6:0], 1'b1};
    endfunction

    // Called at a negedge. Waits (bounded) for ready, accepts in cycle A,
    // scrambles inputs from A+1 on, optionally pulses a busy start.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [47:0] exp, input string nm,
                        input int busy_at);
        int waited;
        logic [47:0] got;
        int en_cnt;
        int bad_ready;
        int bad_pulse;
        int bad_gap;
        waited = 0;
        while (!ready_o && waited < 200) begin
            @(negedge sd_clk_i);
            waited++;
        end
        last_wait = waited;
        chk({nm, " ready_at_A"}, 64'(ready_o), 64'd1);
        start_tx_i  = 1'b1;
        cmd_index_i = idx;
        cmd_arg_i   = arg;
        got = '0;
        en_cnt = 0;
        bad_ready = 0;
        bad_pulse = 0;
        for (int c = 1; c <= 48; c++) begin
            @(negedge sd_clk_i);
            start_tx_i  = (c == busy_at);
            cmd_index_i = (c == busy_at) ? 6'd17 : 6'($urandom);
            cmd_arg_i   = ~arg ^ 32'($urandom);
            got = {got[46:0], cmd_o};
            en_cnt += int'(cmd_en_o);
            if (ready_o) bad_ready++;
            if (done_o || start_listening_o) bad_pulse++;
        end
        start_tx_i = 1'b0;
        chk({nm, " token"}, 64'(got), 64'(exp));
        chk({nm, " en_cycles"}, 64'(en_cnt), 64'd48);
        chk({nm, " busy_ready"}, 64'(bad_ready), 64'd0);
        chk({nm, " early_pulse"}, 64'(bad_pulse), 64'd0);
        @(negedge sd_clk_i);
        chk({nm, " done_A49"}, 64'({done_o, cmd_en_o, cmd_o, ready_o}),
            64'b1010);
        @(negedge sd_clk_i);
        chk({nm, " listen_A50"},
            64'({start_listening_o, done_o, cmd_en_o, ready_o}), 64'b1000);
        bad_gap = 0;
        for (int g = 0; g < GAP; g++) begin
            @(negedge sd_clk_i);
            if (ready_o || cmd_en_o || !cmd_o || done_o || start_listening_o)
                bad_gap++;
        end
        @(negedge sd_clk_i);
        chk({nm, " gap"}, 64'(bad_gap), 64'd0);
        chk({nm, " ready_after"}, 64'(ready_o), 64'd1);
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] tok;
        string       nm;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int pulses;
        int en_cnt;
        logic [5:0]  ri;
        logic [31:0] ra;
        total = 0;
        passed = 0;
        last_wait = 0;
        tbl[0] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095, "CMD0"};
        tbl[1] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87, "CMD8"};
        tbl[2] = '{6'd55, 32'h0000_0000, 48'h7700_0000_0065, "CMD55"};
        tbl[3] = '{6'd41, 32'h40FF_8000,
                   mk_token(6'd41, 32'h40FF_8000), "CMD41"};

        rst_i = 1'b1;
        start_tx_i = 1'b0;
        cmd_index_i = '0;
        cmd_arg_i = '0;
        @(negedge sd_clk_i);
        @(negedge sd_clk_i);
        chk("reset_outputs",
            64'({cmd_o, cmd_en_o, ready_o, done_o, start_listening_o}),
            64'b10100);
        rst_i = 1'b0;
        @(negedge sd_clk_i);

        // Table: consecutive entries run back to back (CMD55 -> CMD41).
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].idx, tbl[i].arg, tbl[i].tok, tbl[i].nm, -1);
            if (i > 0)
                chk({tbl[i].nm, " b2b_wait"}, 64'(last_wait), 64'd0);
        end

        // Start pulse with CMD17 at A+10 is ignored.
        send(6'd0, 32'h0, 48'h4000_0000_0095, "CMD0_busy", 10);

        // Reset mid-token at A+20.
        start_tx_i = 1'b1;
        cmd_index_i = 6'd0;
        cmd_arg_i = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sd_clk_i);
            start_tx_i = 1'b0;
            if (c == 20) rst_i = 1'b1;
        end
        @(negedge sd_clk_i);
        rst_i = 1'b0;
        chk("rst_mid_A21", 64'({cmd_en_o, cmd_o, ready_o}), 64'b011);
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge sd_clk_i);
            if (done_o || start_listening_o || cmd_en_o) pulses++;
        end
        chk("rst_mid_no_pulse", 64'(pulses), 64'd0);
        send(6'd0, 32'h0, 48'h4000_0000_0095, "CMD0_after_rst", -1);

        // Start together with reset is dropped.
        rst_i = 1'b1;
        start_tx_i = 1'b1;
        cmd_index_i = 6'd8;
        @(negedge sd_clk_i);
        rst_i = 1'b0;
        start_tx_i = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sd_clk_i);
            en_cnt += int'(cmd_en_o);
        end
        chk("rst_start_dropped", 64'(en_cnt), 64'd0);
        chk("rst_start_ready", 64'(ready_o), 64'd1);

        // Random commands against the model.
        for (int n = 0; n < 16; n++) begin
            ri = 6'($urandom);
            ra = $urandom;
            send(ri, ra, mk_token(ri, ra), $sformatf("rand%0d", n),
                 (n % 4 == 0) ? int'($urandom_range(1, 48)) : -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
